// File: rtl/program_loader_pkg.sv
// Shared constants for the boot-time program loader: FSM encoding,
// memory direction values and stream byte order.
package program_loader_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_CHECK  = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;
  localparam logic [2:0] ST_ERROR  = 3'd7;

  localparam logic MEM_WRITE = 1'b1;
  localparam logic MEM_READ  = 1'b0;

  // Little-endian stream: the first byte of a word lands in bits [7:0].
  localparam logic [1:0] FIRST_LANE = 2'd0;
  localparam logic [1:0] LAST_LANE  = 2'd3;

  function automatic logic takes_bytes(input logic [2:0] st);
    return (st == ST_LEN_LO) || (st == ST_LEN_HI) ||
           (st == ST_DATA)   || (st == ST_CHECK);
  endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// Assembles four accepted bytes into a little-endian 32-bit word and
// strobes word_ready on the edge that accepts the last byte.
module program_loader_byte_packer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    if (clear) begin
      lane_d = FIRST_LANE;
    end else if (accept) begin
      word_d[{lane_q, 3'b000} +: 8] = byte_in;
      lane_d = lane_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q <= FIRST_LANE;
    end else begin
      lane_q <= lane_d;
    end
  end

  // Word lanes are pure data; every lane is rewritten before it is consumed.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign word       = word_q;
  assign word_ready = accept && (lane_q == LAST_LANE);

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream into
// sequential 32-bit memory writes, then releases the control unit.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_e,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_wData,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [31:0]       MAX_WORDS = (32'd1 << ADDR_W) - 32'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_INIT = ADDR_W'(BASE_ADDR);

  logic [2:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic [7:0]        acc_q, acc_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;

  logic        accept;
  logic        load_go;
  logic        last_word;
  logic [31:0] pk_word;
  logic        pk_word_ready;

  assign accept    = byte_valid && ready_q;
  assign load_go   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                               (state_q == ST_ERROR));
  assign last_word = (32'(wl_q) + 32'd1) == 32'(len_q);

  program_loader_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_go),
    .accept     (accept && (state_q == ST_DATA)),
    .byte_in    (byte_in),
    .word       (pk_word),
    .word_ready (pk_word_ready)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wl_d     = wl_q;
    acc_d    = acc_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_LEN_LO;
          wl_d    = '0;
          acc_d   = '0;
          addr_d  = ADDR_INIT;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_lo_d = byte_in;
          acc_d    = acc_q ^ byte_in;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d   = {byte_in, len_lo_q};
          acc_d   = acc_q ^ byte_in;
          state_d = ((len_d != 16'd0) && ({16'd0, len_d} <= MAX_WORDS)) ? ST_DATA : ST_ERROR;
        end
      end
      ST_DATA: begin
        if (accept) begin
          acc_d = acc_q ^ byte_in;
          if (pk_word_ready) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The final address is held so mem_add never steps past the image.
        wl_d    = wl_q + (ADDR_W+1)'(1);
        wdata_d = pk_word[DATA_W-1:0];
        if (last_word) begin
          state_d = ST_CHECK;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_DATA;
        end
      end
      ST_CHECK: begin
        if (accept) begin
          acc_d   = acc_q ^ byte_in;
          state_d = (acc_d == 8'h00) ? ST_DONE : ST_ERROR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = takes_bytes(state_d);
    hold_d  = (state_d != ST_DONE);
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      addr_q   <= ADDR_INIT;
      wdata_q  <= '0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      wl_q     <= '0;
      acc_q    <= '0;
      len_lo_q <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      error_q  <= error_d;
      wl_q     <= wl_d;
      acc_q    <= acc_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
    end
  end

  // The write cycle presents the freshly packed word; otherwise the last one is held.
  assign mem_e        = (state_q == ST_WRITE);
  assign mem_rw       = (state_q == ST_WRITE) ? MEM_WRITE : MEM_READ;
  assign mem_wData    = (state_q == ST_WRITE) ? pk_word[DATA_W-1:0] : wdata_q;
  assign mem_add      = addr_q;
  assign byte_ready   = ready_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed corner cases, a table of
// length/checksum vectors, and randomized loads against a stream-level model.
module tb_program_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
    logic        side_ok;
  } wr_t;

  typedef struct {
    int   n;
    bit   corrupt;
    int   gap_pct;
    logic exp_done;
    logic exp_error;
    int   exp_words;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_e;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_add;
  logic [31:0]       mem_wData;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  wr_t wlog[$];

  program_loader #(.ADDR_W(ADDR_W), .DATA_W(32), .BASE_ADDR(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_e        (mem_e),
    .mem_rw       (mem_rw),
    .mem_add      (mem_add),
    .mem_wData    (mem_wData),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory-port observer: every write cycle is logged with its side conditions.
  always @(negedge clk) begin : mon
    wr_t w;
    if (reset && mem_e) begin
      w.addr    = int'(mem_add);
      w.data    = mem_wData;
      w.cyc     = cyc;
      w.side_ok = (mem_rw === 1'b1) && (byte_ready === 1'b0) && (cpu_hold === 1'b1);
      wlog.push_back(w);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_bytes(input byte_q_t bs, input int gap_pct, input string tag);
    int  i      = 0;
    int  budget = bs.size() * 40 + 50;
    int  k      = 0;
    bit  xfer;
    while (i < bs.size() && k < budget) begin
      @(negedge clk);
      byte_in    = bs[i];
      byte_valid = ($urandom_range(0, 99) >= gap_pct);
      xfer       = byte_valid && byte_ready;
      @(posedge clk);
      if (xfer) i++;
      k++;
    end
    if (i < bs.size()) check({tag, "_stream_timeout"}, 64'(i), 64'(bs.size()));
    @(negedge clk) byte_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int k = 0;
    @(negedge clk);
    while (!(done || error) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_finished"}, 64'(done || error), 64'd1);
  endtask

  // Reference model: builds the stream and predicts the outcome from the stream rules.
  function automatic void build_stream(input int n, input word_q_t words, input bit corrupt,
                                       output byte_q_t s, output logic exp_done,
                                       output logic exp_error, output int exp_writes);
    logic [7:0]  x;
    logic [15:0] n16;
    n16 = 16'(n);
    s = {};
    s.push_back(n16[7:0]);
    s.push_back(n16[15:8]);
    if (n < 1 || n > DEPTH) begin
      exp_done = 1'b0; exp_error = 1'b1; exp_writes = 0;
      return;
    end
    foreach (words[i]) begin
      logic [31:0] w;
      w = words[i];
      for (int b = 0; b < 4; b++) s.push_back(w[8*b +: 8]);
    end
    x = 8'h00;
    foreach (s[i]) x ^= s[i];
    if (corrupt) x ^= 8'($urandom_range(1, 255));
    s.push_back(x);
    x = 8'h00;
    foreach (s[i]) x ^= s[i];
    exp_done   = (x == 8'h00);
    exp_error  = !exp_done;
    exp_writes = n;
  endfunction

  task automatic run_load(input byte_q_t s, input word_q_t words, input int gap_pct,
                          input logic exp_done, input logic exp_error, input int exp_words,
                          input string tag, output int base);
    int bad;
    int nw;
    base = wlog.size();
    pulse_start();
    check({tag, "_hold_during_load"}, 64'(cpu_hold), 64'd1);
    send_bytes(s, gap_pct, tag);
    wait_end(tag);
    check({tag, "_done"}, 64'(done), 64'(exp_done));
    check({tag, "_error"}, 64'(error), 64'(exp_error));
    check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(!exp_done));
    check({tag, "_words_loaded"}, 64'(words_loaded), 64'(exp_words));
    nw = wlog.size() - base;
    check({tag, "_num_writes"}, 64'(nw), 64'(exp_words));
    bad = 0;
    for (int i = 0; i < exp_words && i < nw; i++) begin
      if (wlog[base+i].addr != i || wlog[base+i].data !== words[i] || !wlog[base+i].side_ok)
        bad++;
    end
    check({tag, "_image_bad_words"}, 64'(bad), 64'd0);
  endtask

  function automatic word_q_t rand_words(input int n);
    word_q_t w;
    w = {};
    if (n >= 1 && n <= DEPTH)
      for (int i = 0; i < n; i++) w.push_back($urandom());
    return w;
  endfunction

  initial begin
    vec_t    vecs[$];
    byte_q_t s;
    word_q_t w;
    int      base;
    logic    ed, ee;
    int      ew;

    reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_byte_ready", 64'(byte_ready), 64'd0);
    check("rst_mem_e", 64'(mem_e), 64'd0);
    check("rst_mem_rw", 64'(mem_rw), 64'd0);
    check("rst_mem_add", 64'(mem_add), 64'd0);
    check("rst_mem_wdata", 64'(mem_wData), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_words_loaded", 64'(words_loaded), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_byte_ready", 64'(byte_ready), 64'd0);

    // Nominal two-word load, back-to-back bytes.
    s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
    w = '{32'h12345678, 32'hDEADBEEF};
    run_load(s, w, 0, 1'b1, 1'b0, 2, "nominal", base);
    if (wlog.size() >= base + 2) begin
      check("nominal_w0_addr", 64'(wlog[base].addr), 64'd0);
      check("nominal_w0_data", 64'(wlog[base].data), 64'h12345678);
      check("nominal_w1_addr", 64'(wlog[base+1].addr), 64'd1);
      check("nominal_w1_data", 64'(wlog[base+1].data), 64'hDEADBEEF);
      check("nominal_cycles_per_word", 64'(wlog[base+1].cyc - wlog[base].cyc), 64'd5);
    end else begin
      check("nominal_write_log", 64'(wlog.size() - base), 64'd2);
    end
    check("done_mem_e", 64'(mem_e), 64'd0);
    check("done_byte_ready", 64'(byte_ready), 64'd0);

    // Restart from DONE with a single word.
    s = '{8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hC8};
    w = '{32'hCAFEF00D};
    run_load(s, w, 0, 1'b1, 1'b0, 1, "restart", base);

    // Bad checksum variant of the nominal stream.
    s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h29};
    w = '{32'h12345678, 32'hDEADBEEF};
    run_load(s, w, 0, 1'b0, 1'b1, 2, "bad_chk", base);

    // Length and checksum table; data words are random, outcomes fixed.
    vecs = '{
      '{n: 2,     corrupt: 1'b0, gap_pct: 0,  exp_done: 1'b1, exp_error: 1'b0, exp_words: 2},
      '{n: 3,     corrupt: 1'b1, gap_pct: 20, exp_done: 1'b0, exp_error: 1'b1, exp_words: 3},
      '{n: 0,     corrupt: 1'b0, gap_pct: 0,  exp_done: 1'b0, exp_error: 1'b1, exp_words: 0},
      '{n: 1025,  corrupt: 1'b0, gap_pct: 0,  exp_done: 1'b0, exp_error: 1'b1, exp_words: 0},
      '{n: 65535, corrupt: 1'b0, gap_pct: 10, exp_done: 1'b0, exp_error: 1'b1, exp_words: 0},
      '{n: 1,     corrupt: 1'b0, gap_pct: 50, exp_done: 1'b1, exp_error: 1'b0, exp_words: 1},
      '{n: 7,     corrupt: 1'b0, gap_pct: 40, exp_done: 1'b1, exp_error: 1'b0, exp_words: 7},
      '{n: 1024,  corrupt: 1'b0, gap_pct: 0,  exp_done: 1'b1, exp_error: 1'b0, exp_words: 1024}
    };
    for (int v = 0; v < vecs.size(); v++) begin
      w = rand_words(vecs[v].n);
      build_stream(vecs[v].n, w, vecs[v].corrupt, s, ed, ee, ew);
      run_load(s, w, vecs[v].gap_pct, vecs[v].exp_done, vecs[v].exp_error,
               vecs[v].exp_words, $sformatf("table%0d", v), base);
      if (vecs[v].n == 1024 && wlog.size() > 0)
        check("table_last_addr", 64'(wlog[wlog.size()-1].addr), 64'h3FF);
    end

    // Randomized loads checked against the stream model.
    for (int r = 0; r < 12; r++) begin
      int n;
      if ($urandom_range(0, 9) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1025, 2000));
      else n = int'($urandom_range(1, 24));
      w = rand_words(n);
      build_stream(n, w, ($urandom_range(0, 3) == 0), s, ed, ee, ew);
      run_load(s, w, int'($urandom_range(0, 60)), ed, ee, ew, $sformatf("rand%0d", r), base);
    end

    // Reset in the middle of a load, after six data bytes.
    pulse_start();
    s = '{8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_bytes(s, 0, "midrst");
    @(negedge clk);
    check("midrst_pre_words_loaded", 64'(words_loaded), 64'd1);
    check("midrst_pre_mem_add", 64'(mem_add), 64'd1);
    reset = 1'b0;
    #1;
    check("midrst_byte_ready", 64'(byte_ready), 64'd0);
    check("midrst_mem_e", 64'(mem_e), 64'd0);
    check("midrst_mem_add", 64'(mem_add), 64'd0);
    check("midrst_mem_wdata", 64'(mem_wData), 64'd0);
    check("midrst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("midrst_words_loaded", 64'(words_loaded), 64'd0);
    check("midrst_done_error", 64'({done, error}), 64'd0);
    @(negedge clk) reset = 1'b1;
    w = rand_words(3);
    build_stream(3, w, 1'b0, s, ed, ee, ew);
    run_load(s, w, 25, ed, ee, ew, "after_rst", base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time stage directly upstream of the 1024x32 data/program memory and the control unit.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes the words to sequential memory addresses, then releases the control unit from hold.
- Owns the memory write port only while loading; the control unit owns it afterwards via an external mux driven by cpu_hold.

Parameters:
ADDR_W, 10, memory address width (depth 2^ADDR_W words)
DATA_W, 32, memory word width; must equal 32
BASE_ADDR, 0, first memory address written

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (low = reset asserted)
start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR
byte_in  input  8  stream byte
byte_valid  input  1  byte_in is valid this cycle
byte_ready  output  1  loader accepts byte_in this cycle
mem_e  output  1  memory enable
mem_rw  output  1  memory direction, 1 = write
mem_add  output  ADDR_W  memory word address
mem_wData  output  32  memory write data
cpu_hold  output  1  1 = control unit held idle, loader owns memory
done  output  1  load completed with good checksum (level)
error  output  1  load aborted (level)
words_loaded  output  ADDR_W+1  words written in the current or last load

Behaviour:
- Reset (reset low, async): state IDLE; byte_ready=0, mem_e=0, mem_rw=0, mem_add=BASE_ADDR, mem_wData=0, cpu_hold=1, done=0, error=0, words_loaded=0, checksum accumulator=0.
- Byte transfer: occurs on an edge where byte_valid=1 and byte_ready=1. byte_ready is registered and never depends combinationally on byte_valid.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4N data bytes (each word LSB first), then one CHK byte.
- Checksum: XOR of every byte of the stream, including LEN and CHK, must be 0x00.
- States:
  - IDLE: byte_ready=0. On start: clear done/error/words_loaded/accumulator, mem_add=BASE_ADDR, go to LEN_LO.
  - LEN_LO, LEN_HI: byte_ready=1; capture the length bytes. After LEN_HI, go to ERROR if N==0 or N > 2^ADDR_W - BASE_ADDR, else to DATA.
  - DATA: byte_ready=1; shift bytes into the word register at lane 0..3. On the 4th byte go to WRITE.
  - WRITE: exactly one cycle; mem_e=1, mem_rw=1, mem_wData=assembled word, mem_add=current address; byte_ready=0. Next edge: words_loaded+1, mem_add+1. Go to CHECK if words_loaded+1==N, else to DATA.
  - CHECK: byte_ready=1; on the CHK byte go to DONE if the final XOR is 0x00, else to ERROR.
  - DONE: done=1, cpu_hold=0, byte_ready=0. start re-enters the load sequence (cpu_hold returns to 1 on the same edge).
  - ERROR: error=1, cpu_hold stays 1, byte_ready=0. start retries the load.
- Memory outputs: mem_e=0 and mem_rw=0 in every state other than WRITE; mem_add and mem_wData hold their last values.
- Latency: the memory write is issued in the cycle after the 4th byte of a word is accepted. Sustained throughput is 5 cycles per word with back-to-back valid.
- Address: mem_add never wraps, because the length check above guarantees the last address is ≤ 2^ADDR_W-1.
- start while in LEN_LO..CHECK is ignored.
- byte_valid while byte_ready=0: the byte is not consumed; the source must hold it.
- Reset mid-load: immediate abort to reset values. Memory contents already written are left as-is.
- words_loaded is retained after DONE/ERROR for diagnostics.

Decomposition:
- Shared package: loader state encoding (IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR), MEM_WRITE=1 / MEM_READ=0 constants, and the stream byte-order constant.
- One natural sub-module: byte_packer (4-byte little-endian shift/assemble with lane counter and word_ready strobe), instantiated once.

Test Plan:
- Nominal load: start; send N=2 (0x02,0x00), bytes 0x78,0x56,0x34,0x12 and 0xEF,0xBE,0xAD,0xDE, then CHK=0x02^0x78^0x56^0x34^0x12^0xEF^0xBE^0xAD^0xDE -> two single-cycle writes: add 0 = 0x12345678, add 1 = 0xDEADBEEF; done=1, cpu_hold=0, words_loaded=2.
- Bad checksum: same stream with CHK XOR 0x01 -> both writes still occur; error=1, done=0, cpu_hold=1.
- Length bounds: N=0 -> ERROR right after LEN_HI with no writes. N=1025 (0x01,0x04) -> ERROR. N=1024 -> last write at add 0x3FF, then DONE.
- Backpressure/gaps: byte_valid toggled randomly, and held high during WRITE -> no byte lost or duplicated; byte_ready=0 during each WRITE cycle; memory image matches the golden model.
- Reset mid-load: assert reset low after 6 data bytes -> outputs return to reset values asynchronously. After release and a fresh start, the new load writes from add 0 and words_loaded restarts at 0.
- Restart: from DONE, start with N=1 (0x01,0x00), word 0xCAFEF00D, CHK=0x01^0x0D^0xF0^0xFE^0xCA -> cpu_hold=1 during the load, add 0 = 0xCAFEF00D, done=1 again, words_loaded=1.
